// File: rtl/mic_dc_fifo_if.sv
// mic_dc_fifo_if: valid/ready stream carrying filtered 16-bit samples
//   data  : signed sample at FIFO head
//   valid : data valid (FIFO non-empty)
//   ready : consumer accepts data when valid & ready
interface mic_dc_fifo_if #(parameter int W = 16);
  logic signed [W-1:0] data;
  logic                valid;
  logic                ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/mic_dc_fifo.sv
// mic_dc_fifo: DC-removal high-pass filter on I2S mic samples feeding a FWFT FIFO
//   clk, rst         : clock, synchronous active-high reset
//   i_sample         : signed 16-bit PCM sample
//   i_sample_valid   : one-cycle strobe qualifying i_sample
//   i_ovf_clr        : clears o_overflow (a drop in the same cycle wins)
//   o_level          : FIFO occupancy 0..DEPTH
//   o_overflow       : sticky, a filtered sample was dropped on a full FIFO
//   m_if             : filtered sample stream out (master)
module mic_dc_fifo #(
  parameter int DEPTH = 16,
  parameter int K     = 8,
  parameter bit DC_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [15:0]       i_sample,
  input  logic                     i_sample_valid,
  input  logic                     i_ovf_clr,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  mic_dc_fifo_if.master            m_if
);
  localparam int AW = $clog2(DEPTH);
  logic signed [15:0] r_x_prev, r_y_prev, r_filt_data;
  logic               r_filt_valid;
  logic signed [15:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [AW:0]        r_level;
  logic               r_overflow;
  logic signed [17:0] w_s;
  logic signed [15:0] w_y;
  logic               w_pop, w_push, w_full;
  // 18 bits hold the worst-case sum of four 16-bit terms without wrapping
  assign w_s = 18'(i_sample) - 18'(r_x_prev) + 18'(r_y_prev) - 18'(r_y_prev >>> K);
  assign w_y = !DC_EN ? i_sample :
               w_s > 18'sd32767 ? 16'sh7fff :
               w_s < -18'sd32768 ? 16'sh8000 : w_s[15:0];
  assign w_full  = r_level == (AW+1)'(DEPTH);
  assign w_pop   = m_if.valid & m_if.ready;
  // a pop frees the slot being written, so a full FIFO still accepts
  assign w_push  = r_filt_valid & (!w_full | w_pop);
  assign m_if.valid = r_level != '0;
  assign m_if.data  = m_if.valid ? r_mem[r_rd] : '0;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_prev     <= '0;
      r_y_prev     <= '0;
      r_filt_data  <= '0;
      r_filt_valid <= 1'b0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_filt_valid <= i_sample_valid;
      if (i_sample_valid) begin
        r_x_prev    <= i_sample;
        r_y_prev    <= w_y;
        r_filt_data <= w_y;
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level    <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_overflow <= (r_filt_valid & !w_push) | (r_overflow & !i_ovf_clr);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= r_filt_data;
endmodule

// File: tb/tb_mic_dc_fifo.sv
// tb_mic_dc_fifo: directed and random checks of mic_dc_fifo against a queue-based model
module tb_mic_dc_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] sample = '0;
  logic sample_valid = 1'b0;
  logic ovf_clr = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  mic_dc_fifo_if m_if();
  mic_dc_fifo #(.DEPTH(DEPTH), .K(8), .DC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_sample(sample), .i_sample_valid(sample_valid),
    .i_ovf_clr(ovf_clr), .o_level(level), .o_overflow(overflow), .m_if(m_if.master)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int q[$];
  int xp = 0, yp = 0, pval = 0;
  bit pv = 0, ovf = 0;
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int floor_div256(input int a);
    return (a < 0 && a % 256 != 0) ? a / 256 - 1 : a / 256;
  endfunction
  function automatic int filt(input int x);
    int s;
    s = x - xp + yp - floor_div256(yp);
    return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
  endfunction
  task automatic cyc(input bit r, input bit sv, input int x, input bit rd, input bit clr);
    bit pop, drop;
    rst = r;
    sample_valid = sv;
    sample = 16'(x);
    m_if.ready = rd;
    ovf_clr = clr;
    @(posedge clk);
    #1;
    pop = q.size() != 0 && rd;
    drop = 0;
    if (r) begin
      q.delete();
      pv = 0; xp = 0; yp = 0; ovf = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (pv) begin
        if (q.size() < DEPTH) q.push_back(pval);
        else drop = 1;
      end
      if (drop) ovf = 1;
      else if (clr) ovf = 0;
      pv = sv;
      if (sv) begin
        pval = filt(x);
        xp = x;
        yp = pval;
      end
    end
    sample_valid = 1'b0;
    ovf_clr = 1'b0;
    check("m_valid", int'(m_if.valid), int'(q.size() != 0));
    check("level", int'(level), q.size());
    check("overflow", int'(overflow), int'(ovf));
    if (q.size() != 0) check("m_data", int'($signed(m_if.data)), q[0]);
  endtask
  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  initial begin
    m_if.ready = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_data", int'($signed(m_if.data)), 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1000, 1, 0);
      repeat (3) cyc(0, 0, 0, 1, 0);
    end
    cyc(0, 1, -500, 0, 0);
    check("lat_t1_valid", int'(m_if.valid), 0);
    cyc(0, 0, 0, 0, 0);
    check("lat_t2_valid", int'(m_if.valid), 1);
    check("lat_t2_level", int'(level), 1);
    cyc(0, 0, 0, 1, 0);
    check("lat_t3_level", int'(level), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32767, 0, 0);
    cyc(0, 1, -32768, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("sat_neg", int'($signed(m_if.data)), -32768);
    cyc(0, 1, 32767, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("sat_pos", int'($signed(m_if.data)), 32767);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, rnd_x(), 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("full_level", int'(level), DEPTH);
    check("full_ovf", int'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0);
    check("drain_level", int'(level), 0);
    cyc(0, 0, 0, 0, 1);
    check("ovf_clr", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, rnd_x(), 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("fill_level", int'(level), DEPTH);
    cyc(0, 1, rnd_x(), 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("pushpop_level", int'(level), DEPTH);
    check("pushpop_ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, rnd_x(), 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("pre_rst_level", int'(level), 5);
    cyc(0, 1, 1234, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_valid", int'(m_if.valid), 0);
    check("rst_level", int'(level), 0);
    cyc(0, 1, 777, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_filt", int'($signed(m_if.data)), 777);
    for (int i = 0; i < 4000; i++) begin
      bit rd;
      rd = ((i / 300) % 2) != 0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1, rnd_x(), rd,
          $urandom_range(0, 29) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
